// File: rtl/button_pio_irq_if.sv
// Avalon-MM slave bus bundle for the button PIO.
// Master drives address/strobes; slave returns readdata and irq.
interface button_pio_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/button_pio_irq.sv
// Debounced, edge-capturing button/switch PIO with maskable irq.
// PIO-compatible map: 0 data, 1 reserved, 2 irqmask, 3 edgecapture.
module button_pio_irq #(
  parameter int          WIDTH           = 4,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          EDGE_TYPE       = 0,
  parameter logic [31:0] IRQ_MASK_RESET  = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  button_pio_irq_if.slave  bus
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int TCI =
    (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
  localparam logic [CW-1:0]    TC       = CW'(TCI);
  localparam logic [WIDTH-1:0] MASK_RST = IRQ_MASK_RESET[WIDTH-1:0];

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_ec;
  logic [31:0]      r_rdata;

  logic [WIDTH-1:0] w_stable_nxt;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_ec_nxt;
  logic [31:0]      w_rmux;
  logic             w_wr;
  logic             w_unused;

  assign w_wr     = bus.chipselect & ~bus.write_n;
  assign w_unused = ^bus.writedata;

  // Two-flop synchroniser on the raw pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign w_stable_nxt[i] = r_sync2[i];
    end else begin : g_cnt
      logic [CW-1:0] r_cnt;
      logic          w_diff;

      assign w_diff = r_sync2[i] ^ r_stable[i];
      assign w_stable_nxt[i] =
        (w_diff && r_cnt == TC) ? r_sync2[i] : r_stable[i];

      // Count while input differs; any match restarts the count.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt <= '0;
        end else if (!w_diff) begin
          r_cnt <= '0;
        end else if (r_cnt == TC) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  // Pick the stable-value transitions that count as edges.
  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      0:       w_edge = w_stable_nxt & ~r_stable;
      1:       w_edge = ~w_stable_nxt & r_stable;
      default: w_edge = w_stable_nxt ^ r_stable;
    endcase
  end

  assign w_clr = (w_wr && bus.address == 2'd3) ?
                 bus.writedata[WIDTH-1:0] : '0;
  // A new edge wins over a simultaneous clear.
  assign w_ec_nxt = (r_ec & ~w_clr) | w_edge;

  // Stable value, edge capture and interrupt mask registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= '0;
      r_ec     <= '0;
      r_mask   <= MASK_RST;
    end else begin
      r_stable <= w_stable_nxt;
      r_ec     <= w_ec_nxt;
      if (w_wr && bus.address == 2'd2) begin
        r_mask <= bus.writedata[WIDTH-1:0];
      end
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    w_rmux = '0;
    case (bus.address)
      2'd0:    w_rmux = 32'(r_stable);
      2'd2:    w_rmux = 32'(r_mask);
      2'd3:    w_rmux = 32'(r_ec);
      default: w_rmux = '0;
    endcase
  end

  // Registered read data, refreshed every clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rmux;
    end
  end

  assign bus.readdata = r_rdata;
  assign bus.irq      = |(r_ec & r_mask);

endmodule
